// File: rtl/pulse_to_level_if.sv
// pulse_to_level_if -- signal bundle for the pulse_to_level stretcher.
//
// Signals:
//   P     trigger into the stretcher (rising edge counts)
//   L     stretched level, high while a hold is in progress
//   busy  mirror of L
//   done  one-cycle pulse marking the end of a hold
//
// Modports:
//   master  drives P, observes L/busy/done (the trigger source)
//   slave   samples P, drives L/busy/done (the stretcher)

interface pulse_to_level_if;
  logic P;
  logic L;
  logic busy;
  logic done;

  modport master (
    output P,
    input  L,
    input  busy,
    input  done
  );

  modport slave (
    input  P,
    output L,
    output busy,
    output done
  );
endinterface

// File: rtl/pulse_to_level.sv
// pulse_to_level -- stretches a rising edge on P into a level L held for
// HOLD_TICKS * DIV_COUNT clock cycles, followed by a one-cycle done pulse.
//
// Parameters:
//   DIV_COUNT   clocks per timing tick (2 .. 2^24)
//   DIV_WIDTH   prescaler width, 2^DIV_WIDTH >= DIV_COUNT
//   HOLD_TICKS  ticks per hold (1 .. 2^TICK_WIDTH-1)
//   TICK_WIDTH  hold tick counter width
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pulse_to_level_if.slave: P in; L, busy, done out (all registered)
//
// Build option:
//   RETRIGGER_EN  when defined, a trigger during HOLD restarts the full hold window
//                 (including on the final-tick cycle, which then suppresses DONE).
//                 When undefined, triggers during HOLD are dropped.

module pulse_to_level #(
  parameter int unsigned DIV_COUNT  = 4,
  parameter int unsigned DIV_WIDTH  = 25,
  parameter int unsigned HOLD_TICKS = 3,
  parameter int unsigned TICK_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pulse_to_level_if.slave   bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [DIV_WIDTH-1:0]  PrescLast = DIV_WIDTH'(DIV_COUNT - 1);
  localparam logic [TICK_WIDTH-1:0] TickLast  = TICK_WIDTH'(HOLD_TICKS - 1);

  state_e                state_q, state_d;
  logic                  p_q;
  logic                  sampled_q;
  logic [DIV_WIDTH-1:0]  presc_q, presc_d;
  logic [TICK_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
  logic                  l_q, l_d;
  logic                  done_q, done_d;

  logic                  trig;
  logic                  tick;
  logic                  last_tick;

  // p_q is only a trustworthy "previous P" once one edge has passed since reset
  // release; without this, P already high at release would look like a rising edge.
  assign trig      = bus.P & ~p_q & sampled_q;

  assign tick      = (state_q == StHold) && (presc_q == PrescLast);
  assign last_tick = tick && (tick_cnt_q == TickLast);

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    presc_d    = '0;
    tick_cnt_d = '0;
    l_d        = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Counters stay parked at zero while idle.
        if (trig) begin
          state_d = StHold;
          l_d     = 1'b1;
        end
      end

      StHold: begin
        l_d        = 1'b1;
        presc_d    = tick ? '0 : presc_q + DIV_WIDTH'(1);
        tick_cnt_d = tick ? tick_cnt_q + TICK_WIDTH'(1) : tick_cnt_q;
        if (last_tick) begin
          state_d    = StDone;
          l_d        = 1'b0;
          done_d     = 1'b1;
          presc_d    = '0;
          tick_cnt_d = '0;
        end
`ifdef RETRIGGER_EN
        // A retrigger wins over the final tick: the window restarts and DONE is skipped.
        if (trig) begin
          state_d    = StHold;
          l_d        = 1'b1;
          done_d     = 1'b0;
          presc_d    = '0;
          tick_cnt_d = '0;
        end
`endif
      end

      StDone: begin
        // done_q is already high for this cycle; a trigger here starts a fresh hold.
        if (trig) begin
          state_d = StHold;
          l_d     = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      p_q        <= 1'b0;
      sampled_q  <= 1'b0;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      l_q        <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= bus.P;
      sampled_q  <= 1'b1;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      l_q        <= l_d;
      done_q     <= done_d;
    end
  end

  assign bus.L    = l_q;
  assign bus.busy = l_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_pulse_to_level.sv
// tb_pulse_to_level -- directed bench for pulse_to_level.
// Cycle k is the interval ending at clock edge k: P driven in cycle k is sampled
// at edge k, and outputs checked in cycle k are those registered at edge k-1.
// u_dut_a: DIV_COUNT=4, HOLD_TICKS=3.  u_dut_b: DIV_COUNT=2, HOLD_TICKS=1.

module tb_pulse_to_level;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  pulse_to_level_if if_a ();
  pulse_to_level_if if_b ();

  pulse_to_level #(
    .DIV_COUNT (4),
    .DIV_WIDTH (25),
    .HOLD_TICKS(3),
    .TICK_WIDTH(8)
  ) u_dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_a.slave)
  );

  pulse_to_level #(
    .DIV_COUNT (2),
    .DIV_WIDTH (2),
    .HOLD_TICKS(1),
    .TICK_WIDTH(2)
  ) u_dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_b.slave)
  );

  always #5 clk = ~clk;

  // Drive P for the current cycle, advance through its edge, settle 1 unit.
  task automatic step(input logic pa, input logic pb);
    if_a.P = pa;
    if_b.P = pb;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_start();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    cyc = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_a.P = 1'b1;
    if_b.P = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (if_a.L !== 1'b0 || if_a.busy !== 1'b0 || if_a.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: L=%b busy=%b done=%b, want 0 0 0", if_a.L, if_a.busy, if_a.done);
    end
    checks++;
    if (if_b.L !== 1'b0 || if_b.busy !== 1'b0 || if_b.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: L=%b busy=%b done=%b, want 0 0 0", if_b.L, if_b.busy, if_b.done);
    end
    // Release with P already high: no trigger may result.
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if (if_a.L !== 1'b0 || if_a.done !== 1'b0 || if_b.L !== 1'b0 || if_b.done !== 1'b0) begin
        errors++;
        $display("FAIL p_high_at_release step %0d: a L=%b done=%b b L=%b done=%b, want all 0",
                 i, if_a.L, if_a.done, if_b.L, if_b.done);
      end
    end
  endtask

  task automatic test_single_pulse();
    logic exp_l, exp_d;
    idle_start();
    for (int c = 1; c <= 30; c++) begin
      step(c == 10, 1'b0);
      exp_l = (cyc >= 11 && cyc <= 22);
      exp_d = (cyc == 23);
      checks++;
      if (if_a.L !== exp_l || if_a.busy !== exp_l || if_a.done !== exp_d) begin
        errors++;
        $display("FAIL single_pulse cyc %0d: L=%b busy=%b done=%b, want L=%b busy=%b done=%b",
                 cyc, if_a.L, if_a.busy, if_a.done, exp_l, exp_l, exp_d);
      end
    end
  endtask

  task automatic test_held_high();
    logic exp_l, exp_d;
    int   l_cnt = 0;
    int   d_cnt = 0;
    idle_start();
    for (int c = 1; c <= 50; c++) begin
      step(c >= 5 && c <= 44, 1'b0);
      exp_l = (cyc >= 6 && cyc <= 17);
      exp_d = (cyc == 18);
      if (if_a.L === 1'b1) l_cnt++;
      if (if_a.done === 1'b1) d_cnt++;
      checks++;
      if (if_a.L !== exp_l || if_a.busy !== exp_l || if_a.done !== exp_d) begin
        errors++;
        $display("FAIL held_high cyc %0d: L=%b busy=%b done=%b, want L=%b busy=%b done=%b",
                 cyc, if_a.L, if_a.busy, if_a.done, exp_l, exp_l, exp_d);
      end
    end
    checks++;
    if (l_cnt != 12 || d_cnt != 1) begin
      errors++;
      $display("FAIL held_high_totals: L cycles=%0d done pulses=%0d, want 12 and 1", l_cnt, d_cnt);
    end
  endtask

  task automatic test_retrigger();
    logic exp_l, exp_d;
    idle_start();
    for (int c = 1; c <= 36; c++) begin
      step(c == 10 || c == 18, 1'b0);
`ifdef RETRIGGER_EN
      exp_l = (cyc >= 11 && cyc <= 30);
      exp_d = (cyc == 31);
`else
      exp_l = (cyc >= 11 && cyc <= 22);
      exp_d = (cyc == 23);
`endif
      checks++;
      if (if_a.L !== exp_l || if_a.busy !== exp_l || if_a.done !== exp_d) begin
        errors++;
        $display("FAIL retrigger cyc %0d: L=%b busy=%b done=%b, want L=%b busy=%b done=%b",
                 cyc, if_a.L, if_a.busy, if_a.done, exp_l, exp_l, exp_d);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_l, exp_d;
    idle_start();
    for (int c = 1; c <= 40; c++) begin
      step(c == 10 || c == 23, 1'b0);
      exp_l = (cyc >= 11 && cyc <= 22) || (cyc >= 24 && cyc <= 35);
      exp_d = (cyc == 23) || (cyc == 36);
      checks++;
      if (if_a.L !== exp_l || if_a.busy !== exp_l || if_a.done !== exp_d) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: L=%b busy=%b done=%b, want L=%b busy=%b done=%b",
                 cyc, if_a.L, if_a.busy, if_a.done, exp_l, exp_l, exp_d);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic exp_l, exp_d;
    idle_start();
    for (int c = 1; c <= 42; c++) begin
      step(c == 10 || c == 25, 1'b0);
      exp_l = (cyc >= 11 && cyc <= 15) || (cyc >= 26 && cyc <= 37);
      exp_d = (cyc == 38);
      checks++;
      if (if_a.L !== exp_l || if_a.busy !== exp_l || if_a.done !== exp_d) begin
        errors++;
        $display("FAIL reset_mid_hold cyc %0d: L=%b busy=%b done=%b, want L=%b busy=%b done=%b",
                 cyc, if_a.L, if_a.busy, if_a.done, exp_l, exp_l, exp_d);
      end
      if (cyc == 15) begin
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (if_a.L !== 1'b0 || if_a.busy !== 1'b0 || if_a.done !== 1'b0) begin
          errors++;
          $display("FAIL async_reset: L=%b busy=%b done=%b, want 0 0 0",
                   if_a.L, if_a.busy, if_a.done);
        end
      end
      if (cyc == 17) #2 rst_n = 1'b1;
    end
  endtask

  task automatic test_min_config();
    logic exp_l, exp_d;
    idle_start();
    for (int c = 1; c <= 10; c++) begin
      step(1'b0, c == 3);
      exp_l = (cyc >= 4 && cyc <= 5);
      exp_d = (cyc == 6);
      checks++;
      if (if_b.L !== exp_l || if_b.busy !== exp_l || if_b.done !== exp_d) begin
        errors++;
        $display("FAIL min_config cyc %0d: L=%b busy=%b done=%b, want L=%b busy=%b done=%b",
                 cyc, if_b.L, if_b.busy, if_b.done, exp_l, exp_l, exp_d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_held_high();
    test_retrigger();
    test_back_to_back();
    test_reset_mid_hold();
    test_min_config();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
